c17_bist_ctrl: RTL and testbench
================================

Name: c17_bist_ctrl

Overview:
- Built-in self-test sequencer for the dual-c17 NAND netlist (10 primary inputs, 4 primary outputs).
- Generates pseudo-random input vectors with a 10-bit LFSR and drives them onto the netlist inputs.
- Compacts the netlist outputs into an 8-bit MISR signature and compares the final signature against a golden value.
- Sits between a test host (start/pass/done) and the combinational netlist instance.

Parameters:
- LFSR_SEED, 10'h001, initial LFSR state; must be nonzero.
- MISR_SEED, 8'h00, initial MISR state.
- CNT_W, 16, width of pattern-count input and internal counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a test run; honoured only in IDLE or DONE.
- num_patterns  input  CNT_W  number of vectors to apply; sampled on start.
- golden_sig  input  8  expected signature; sampled on start.
- dut_in  output  10  vector to netlist: [0]=N1 [1]=N2 [2]=N3 [3]=N6 [4]=N7 [5]=N17 [6]=N34 [7]=N51 [8]=N102 [9]=N119.
- dut_out  input  4  netlist response: [0]=N22 [1]=N23 [2]=N374 [3]=N391.
- busy  output  1  high from the cycle after start until DONE is entered.
- done  output  1  high while in DONE.
- pass  output  1  valid when done=1: signature == golden.
- signature  output  8  current MISR contents.

Behaviour:
- Reset (synchronous, rst=1 at clock edge) values:
  - state=IDLE, dut_in=10'h000, busy=0, done=0, pass=0.
  - signature=MISR_SEED, LFSR=LFSR_SEED, counter=0.
- Reset mid-run aborts the run immediately. No partial result is kept.
- FSM states: IDLE, APPLY, CAPTURE, DONE.
- IDLE/DONE, start=1:
  - num_patterns==0: go to DONE. signature=MISR_SEED; pass = (MISR_SEED==golden_sig).
  - otherwise: load counter=num_patterns, LFSR=LFSR_SEED, MISR=MISR_SEED, latch golden; go to APPLY.
  - done drops on the transition.
- APPLY (1 cycle):
  - dut_in is registered, equal to the LFSR state, and stable.
  - Next state is CAPTURE.
- CAPTURE (1 cycle):
  - MISR absorbs dut_out.
  - LFSR advances.
  - counter decrements.
  - counter was 1 -> DONE; else -> APPLY.
- Each pattern takes exactly 2 cycles. A run of N patterns reaches DONE 2N+1 edges after the start edge.
- dut_in holds its value through CAPTURE. It changes only on the CAPTURE->APPLY edge, to the new LFSR state.
- In IDLE/DONE, dut_in holds the last applied vector (after reset: 0).
- LFSR (x^10+x^7+1, Fibonacci, shift left):
  - next = {q[8:0], q[9]^q[6]}.
  - Sequence from 0x001: 001,002,004,008,010,020,040,081,102,204...
- MISR (x^8+x^6+x^5+x^4+1):
  - next = {m[6:0], m[7]^m[5]^m[4]^m[3]} ^ {4'b0, dut_out}.
- pass and signature are stable in DONE until the next start or rst.
- start while busy is ignored.
- start and rst in the same cycle: rst wins.

Decomposition:
- Shared package c17_bist_pkg holds:
  - state enum;
  - LFSR/MISR tap constants;
  - DUT_IN_W=10, DUT_OUT_W=4, SIG_W=8.
- One natural sub-module: bist_lfsr_misr. It holds the LFSR and MISR registers with load/step enables; the top keeps the FSM and counter.

Test Plan:
- Single pattern: rst, then start with num_patterns=1, golden=0x00, netlist connected. Expected:
  - dut_in=0x001 in APPLY; dut_out=0.
  - done asserts 3 edges after start; signature=0x00; pass=1.
- Forced response: bench drives dut_out=4'hF constantly, num_patterns=2. Expected:
  - signature=0x0F after the first CAPTURE.
  - signature=0x10 at DONE.
  - golden=0x10 gives pass=1; golden=0x11 gives pass=0.
- LFSR walk: num_patterns=8. dut_in in successive APPLY cycles must be 001,002,004,008,010,020,040,081.
- Zero count: start with num_patterns=0, golden=0x00. Expected: DONE on the next edge, busy never high, pass=1.
- Abort/ignore: start with num_patterns=100.
  - A second start in cycle 5 is ignored; the run still completes at edge 201.
  - A repeat run with rst asserted at cycle 20 gives IDLE, outputs at reset values, and done=0 on the next edge.
- Fault detection: golden from the fault-free 64-pattern run. With N11 stuck-at-0 injected in the netlist model, the rerun gives pass=0 and a signature differing from golden.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// rtl/c17_bist_pkg.sv - shared types, widths and polynomial helpers for the c17 BIST sequencer
// Contents: FSM state enum, netlist/signature widths, LFSR/MISR tap masks, next-state helpers.
package c17_bist_pkg;

    localparam int DUT_IN_W  = 10;
    localparam int DUT_OUT_W = 4;
    localparam int SIG_W     = 8;

    // x^10 + x^7 + 1: feedback is q[9]^q[6]
    localparam logic [DUT_IN_W-1:0] LFSR_TAPS = 10'h240;
    // x^8 + x^6 + x^5 + x^4 + 1: feedback is m[7]^m[5]^m[4]^m[3]
    localparam logic [SIG_W-1:0]    MISR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_t;

    function automatic logic [DUT_IN_W-1:0] lfsr_next(input logic [DUT_IN_W-1:0] q);
        return {q[DUT_IN_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0]     m,
                                                   input logic [DUT_OUT_W-1:0] r);
        return {m[SIG_W-2:0], ^(m & MISR_TAPS)} ^ {{(SIG_W-DUT_OUT_W){1'b0}}, r};
    endfunction

endpackage

// File: rtl/c17_bist_ctrl_if.sv
// rtl/c17_bist_ctrl_if.sv - host and netlist signal bundle for the c17 BIST sequencer
// Host side: start, num_patterns, golden_sig in; busy, done, pass, signature out.
// Netlist side: dut_in drives the netlist inputs, dut_out returns its outputs.
// slave modport is the sequencer view; master modport is the host/netlist view.
interface c17_bist_ctrl_if #(
    parameter int CNT_W = 16
);
    import c17_bist_pkg::*;

    logic                 start;
    logic [CNT_W-1:0]     num_patterns;
    logic [SIG_W-1:0]     golden_sig;
    logic [DUT_IN_W-1:0]  dut_in;
    logic [DUT_OUT_W-1:0] dut_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [SIG_W-1:0]     signature;

    modport master (
        output start, num_patterns, golden_sig, dut_out,
        input  dut_in, busy, done, pass, signature
    );

    modport slave (
        input  start, num_patterns, golden_sig, dut_out,
        output dut_in, busy, done, pass, signature
    );

endinterface

// File: rtl/bist_lfsr_misr.sv
// rtl/bist_lfsr_misr.sv - pattern LFSR and response MISR registers with load/step enables
// Ports: clk, rst (sync active-high), i_load (reseed both), i_step (advance both),
//        i_dut_out (response absorbed on step), o_lfsr_next, o_misr, o_misr_next.
module bist_lfsr_misr
    import c17_bist_pkg::*;
#(
    parameter logic [DUT_IN_W-1:0] LFSR_SEED = 10'h001,
    parameter logic [SIG_W-1:0]    MISR_SEED = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [DUT_OUT_W-1:0] i_dut_out,
    output logic [DUT_IN_W-1:0]  o_lfsr_next,
    output logic [SIG_W-1:0]     o_misr,
    output logic [SIG_W-1:0]     o_misr_next
);

    logic [DUT_IN_W-1:0] r_lfsr;
    logic [SIG_W-1:0]    r_misr;
    logic [DUT_IN_W-1:0] w_lfsr_next;
    logic [SIG_W-1:0]    w_misr_next;

    assign w_lfsr_next = lfsr_next(r_lfsr);
    assign w_misr_next = misr_next(r_misr, i_dut_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
            r_misr <= MISR_SEED;
        end else if (i_load) begin
            r_lfsr <= LFSR_SEED;
            r_misr <= MISR_SEED;
        end else if (i_step) begin
            r_lfsr <= w_lfsr_next;
            r_misr <= w_misr_next;
        end
    end

    assign o_lfsr_next = w_lfsr_next;
    assign o_misr      = r_misr;
    assign o_misr_next = w_misr_next;

endmodule

// File: rtl/c17_bist_ctrl.sv
// rtl/c17_bist_ctrl.sv - BIST sequencer driving the dual-c17 netlist and checking its signature
// Ports: clk, rst (sync active-high), bus (c17_bist_ctrl_if.slave): start/num_patterns/golden_sig
//        from the host, busy/done/pass/signature back to it, dut_in/dut_out to the netlist.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter logic [DUT_IN_W-1:0] LFSR_SEED = 10'h001,
    parameter logic [SIG_W-1:0]    MISR_SEED = 8'h00,
    parameter int                  CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    c17_bist_ctrl_if.slave   bus
);

    bist_state_t         r_state;
    bist_state_t         w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [SIG_W-1:0]    r_golden;
    logic [DUT_IN_W-1:0] r_dut_in;
    logic                r_pass;

    logic                w_load;
    logic                w_step;
    logic                w_num_zero;
    logic                w_cnt_last;
    logic [DUT_IN_W-1:0] w_lfsr_next;
    logic [SIG_W-1:0]    w_misr;
    logic [SIG_W-1:0]    w_misr_next;

    assign w_num_zero = (bus.num_patterns == '0);
    assign w_cnt_last = (r_cnt == CNT_W'(1));

    bist_lfsr_misr #(
        .LFSR_SEED (LFSR_SEED),
        .MISR_SEED (MISR_SEED)
    ) u_lfsr_misr (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_dut_out   (bus.dut_out),
        .o_lfsr_next (w_lfsr_next),
        .o_misr      (w_misr),
        .o_misr_next (w_misr_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = w_num_zero ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_step       = 1'b1;
                w_state_next = w_cnt_last ? ST_DONE : ST_APPLY;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_golden <= '0;
            r_dut_in <= '0;
            r_pass   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_cnt    <= bus.num_patterns;
                r_golden <= bus.golden_sig;
                // An empty run finishes at once with the seed as its signature.
                r_pass   <= w_num_zero && (MISR_SEED == bus.golden_sig);
                if (!w_num_zero) begin
                    r_dut_in <= LFSR_SEED;
                end
            end
            if (w_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_cnt_last) begin
                    // Compare the value the MISR is about to hold, so pass is ready with done.
                    r_pass <= (w_misr_next == r_golden);
                end else begin
                    // dut_in only moves on CAPTURE->APPLY; it keeps the last vector in DONE.
                    r_dut_in <= w_lfsr_next;
                end
            end
        end
    end

    assign bus.dut_in    = r_dut_in;
    assign bus.busy      = (r_state == ST_APPLY) || (r_state == ST_CAPTURE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.pass      = r_pass;
    assign bus.signature = w_misr;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// tb/tb_c17_bist_ctrl.sv - scoreboard bench for c17_bist_ctrl with a dual-c17 netlist model
module tb_c17_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    c17_bist_ctrl_if #(.CNT_W(16)) bus ();

    c17_bist_ctrl #(
        .LFSR_SEED (10'h001),
        .MISR_SEED (8'h00),
        .CNT_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] sig;
        logic       pass;
        int         t_done;
    } res_t;

    int         checks = 0;
    int         errors = 0;
    int         edge_cnt = 0;
    int         bidx = 0;
    int         busy_cycles = 0;
    bit         done_prev = 1'b0;
    bit         fault_n11 = 1'b0;
    bit         forced = 1'b0;
    logic [9:0] cur_vec = '0;
    logic [9:0] q_vec[$];
    res_t       q_res[$];

    // Gate-level behaviour of two c17 copies; the second copy uses N17/N34/N51/N102/N119
    // in the roles of N1/N2/N3/N6/N7.
    function automatic logic [3:0] c17_eval(input logic [9:0] v, input bit sa0_n11);
        logic n10, n11, n16, n19, n22, n23;
        logic m10, m11, m16, m19, n374, n391;
        n10  = ~(v[0] & v[2]);
        n11  = sa0_n11 ? 1'b0 : ~(v[2] & v[3]);
        n16  = ~(v[1] & n11);
        n19  = ~(n11 & v[4]);
        n22  = ~(n10 & n16);
        n23  = ~(n16 & n19);
        m10  = ~(v[5] & v[7]);
        m11  = ~(v[7] & v[8]);
        m16  = ~(v[6] & m11);
        m19  = ~(m11 & v[9]);
        n374 = ~(m10 & m16);
        n391 = ~(m16 & m19);
        return {n391, n374, n23, n22};
    endfunction

    assign bus.dut_out = forced ? 4'hF : c17_eval(bus.dut_in, fault_n11);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: polynomial arithmetic on ints, pushes each vector expected in APPLY.
    task automatic model_run(input int n, output logic [7:0] sig);
        int q;
        int m;
        int resp;
        int fb;
        q = 1;
        m = 0;
        for (int i = 0; i < n; i++) begin
            q_vec.push_back(10'(q));
            resp = forced ? 15 : int'(c17_eval(10'(q), fault_n11));
            fb   = ((m >> 7) ^ (m >> 5) ^ (m >> 4) ^ (m >> 3)) & 1;
            m    = (((m << 1) | fb) & 255) ^ resp;
            q    = ((q << 1) & 1023) | (((q >> 9) ^ (q >> 6)) & 1);
        end
        sig = 8'(m);
    endtask

    task automatic do_start(input int n, input logic [7:0] golden, input logic [7:0] exp_sig,
                            output int t0);
        res_t r;
        @(posedge clk);
        #1;
        t0 = edge_cnt;
        bus.start        = 1'b1;
        bus.num_patterns = 16'(n);
        bus.golden_sig   = golden;
        r.sig    = exp_sig;
        r.pass   = (exp_sig == golden);
        r.t_done = t0 + 2 * n + 1;
        q_res.push_back(r);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!bus.done && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_within_budget", {31'b0, bus.done}, 32'd1);
    endtask

    task automatic run(input int n, input bit use_model, input logic [7:0] gval,
                       output logic [7:0] sig_out);
        logic [7:0] s;
        logic [7:0] g;
        int t0;
        model_run(n, s);
        g = use_model ? s : gval;
        do_start(n, g, s, t0);
        wait_done(2 * n + 10);
        sig_out = s;
    endtask

    always @(posedge clk) edge_cnt++;

    // Monitor: vectors during busy, result on each rising done.
    always @(negedge clk) begin
        res_t r;
        if (bus.busy) begin
            busy_cycles++;
            if (bidx % 2 == 0) begin
                if (q_vec.size() == 0) begin
                    check("apply_vec_expected", 32'd0, 32'd1);
                end else begin
                    cur_vec = q_vec.pop_front();
                    check("apply_dut_in", {22'b0, bus.dut_in}, {22'b0, cur_vec});
                end
            end else begin
                check("capture_dut_in_hold", {22'b0, bus.dut_in}, {22'b0, cur_vec});
            end
            bidx++;
        end else begin
            bidx = 0;
        end
        if (bus.done && !done_prev) begin
            if (q_res.size() == 0) begin
                check("done_result_expected", 32'd0, 32'd1);
            end else begin
                r = q_res.pop_front();
                check("done_signature", {24'b0, bus.signature}, {24'b0, r.sig});
                check("done_pass", {31'b0, bus.pass}, {31'b0, r.pass});
                check("done_edge", edge_cnt, r.t_done);
            end
        end
        done_prev = bus.done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic [7:0] sg;
        logic [7:0] g;
        int         t0;
        int         b0;

        bus.start        = 1'b0;
        bus.num_patterns = '0;
        bus.golden_sig   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_dut_in", {22'b0, bus.dut_in}, 32'h0);
        check("reset_busy", {31'b0, bus.busy}, 32'h0);
        check("reset_done", {31'b0, bus.done}, 32'h0);
        check("reset_pass", {31'b0, bus.pass}, 32'h0);
        check("reset_signature", {24'b0, bus.signature}, 32'h0);

        // Single pattern: vector 001 gives an all-zero response.
        run(1, 1'b0, 8'h00, s);
        check("single_pass", {31'b0, bus.pass}, 32'd1);

        // Forced all-ones response over two patterns.
        forced = 1'b1;
        model_run(2, s);
        do_start(2, 8'h10, s, t0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("forced_first_capture", {24'b0, bus.signature}, 32'h0F);
        wait_done(10);
        check("forced_final_sig", {24'b0, bus.signature}, 32'h10);
        check("forced_pass_match", {31'b0, bus.pass}, 32'd1);
        run(2, 1'b0, 8'h11, s);
        check("forced_pass_mismatch", {31'b0, bus.pass}, 32'd0);
        forced = 1'b0;

        // LFSR walk over eight vectors.
        run(8, 1'b0, 8'($urandom), s);

        // Abort/ignore: a start while busy is ignored.
        model_run(100, s);
        g = 8'($urandom);
        do_start(100, g, s, t0);
        while (edge_cnt < t0 + 4) begin
            @(posedge clk);
            #1;
        end
        bus.start        = 1'b1;
        bus.num_patterns = 16'd3;
        bus.golden_sig   = ~g;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(250);
        check("abort_ignored_pass", {31'b0, bus.pass}, {31'b0, s == g});

        // Reset in the middle of a run.
        model_run(100, s);
        do_start(100, s, s, t0);
        while (edge_cnt < t0 + 19) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_pass", {31'b0, bus.pass}, 32'd0);
        check("midrst_dut_in", {22'b0, bus.dut_in}, 32'h0);
        check("midrst_signature", {24'b0, bus.signature}, 32'h0);
        q_vec.delete();
        q_res.delete();
        @(posedge clk);
        #1;
        check("midrst_done_next", {31'b0, bus.done}, 32'd0);

        // Zero count from IDLE.
        b0 = busy_cycles;
        do_start(0, 8'h00, 8'h00, t0);
        wait_done(5);
        check("zero_busy_never", busy_cycles, b0);
        check("zero_pass", {31'b0, bus.pass}, 32'd1);

        // Random runs, golden either correct or random.
        for (int i = 0; i < 6; i++) begin
            run(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 8'($urandom), s);
        end

        // Fault detection with N11 stuck-at-0.
        fault_n11 = 1'b0;
        run(64, 1'b1, 8'h00, sg);
        check("fault_free_pass", {31'b0, bus.pass}, 32'd1);
        fault_n11 = 1'b1;
        run(64, 1'b0, sg, s);
        check("fault_pass", {31'b0, bus.pass}, 32'd0);
        check("fault_sig_differs", {31'b0, bus.signature != sg}, 32'd1);
        fault_n11 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("vec_queue_drained", q_vec.size(), 32'd0);
        check("res_queue_drained", q_res.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
